// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types (package)
// Purpose  : Shared CPU-wide types: reservation-station tag, common data bus
//            payload, and the default completion-queue depth.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types;

  // Reservation-station tag carried on the CDB.
  typedef logic [3:0] RS_tag_type;

  // One CDB broadcast: producing tag plus result value.
  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

  // Default number of completion-queue entries.
  localparam int CQ_DEPTH_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/cq_push_compactor.sv
`default_nettype none
// ============================================================================
// Module   : cq_push_compactor
// Purpose  : Prefix popcount of a push-valid vector. Each channel receives
//            the number of valid channels below it (its compacted write
//            offset); the total valid count is also produced.
// Ports    : i_valid  [NUM_CH]        per-channel push enable
//            o_offset [NUM_CH*OFF_W]   channel i offset at [i*OFF_W +: OFF_W]
//            o_total  [OFF_W]          number of set bits in i_valid
// Revision : 1.0 - initial release
// ============================================================================
module cq_push_compactor
  import cpu_types::*;
#(
  parameter int NUM_CH = 4,
  parameter int OFF_W  = $clog2(NUM_CH + 1)
) (
  input  logic [NUM_CH-1:0]       i_valid,
  output logic [NUM_CH*OFF_W-1:0] o_offset,
  output logic [OFF_W-1:0]        o_total
);

  logic [OFF_W-1:0] w_acc;

  // Running sum: each channel sees the count of valid channels strictly
  // below it, which makes the pushed entries land contiguously.
  always_comb begin
    w_acc    = '0;
    o_offset = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_offset[i*OFF_W +: OFF_W] = w_acc;
      w_acc = w_acc + OFF_W'(i_valid[i]);
    end
    o_total = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/cdb_completion_queue.sv
`default_nettype none
// ============================================================================
// Module   : cdb_completion_queue
// Purpose  : Collects results from NUM_CH execution units into an oldest-first
//            circular queue and broadcasts one entry per cycle on the CDB.
//            Lower channel index is older within a cycle. FLUSH empties the
//            queue and discards same-cycle traffic.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_tag/in_data   packed per-channel producer results
//            in_ready                  all channels may push this cycle
//            flush                     synchronous clear
//            cdb_ready                 consumer takes the head entry
//            cdb_valid/cdb_tag/cdb_data head entry
//            count                     registered occupancy
// Revision : 1.0 - initial release
// ============================================================================
module cdb_completion_queue
  import cpu_types::*;
#(
  parameter int NUM_CH = 4,                    // 1..8
  parameter int DEPTH  = CQ_DEPTH_DEFAULT,     // power of two, >= NUM_CH, >= 2
  parameter int DATA_W = 32,
  parameter int TAG_W  = $bits(RS_tag_type)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*TAG_W-1:0]    in_tag,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       cdb_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  // Pointer sums carry one spare bit so WP + offset never wraps before the
  // explicit modulo.
  localparam int SUM_W = ((PTR_W > PC_W) ? PTR_W : PC_W) + 1;

  logic [PTR_W-1:0]       wp_q, wp_d;
  logic [PTR_W-1:0]       rp_q, rp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [TAG_W-1:0]       mem_tag  [DEPTH];
  logic [DATA_W-1:0]      mem_data [DEPTH];

  logic [CNT_W-1:0]       w_free;
  logic [NUM_CH-1:0]      w_push_en;
  logic [NUM_CH*PC_W-1:0] w_push_off;
  logic [PC_W-1:0]        w_push_cnt;
  logic                   w_pop;
  logic [PTR_W-1:0]       w_slot   [NUM_CH];
  logic [SUM_W-1:0]       w_wp_sum;

  // Readiness looks only at the registered count: a same-cycle pop never
  // makes room for a push, which keeps in_ready off the cdb_ready path.
  assign w_free    = CNT_W'(DEPTH) - cnt_q;
  assign in_ready  = (w_free >= CNT_W'(NUM_CH));
  assign w_push_en = in_valid & {NUM_CH{in_ready & ~flush}};
  assign w_pop     = (cnt_q != '0) && cdb_ready && !flush;

  cq_push_compactor #(
    .NUM_CH (NUM_CH),
    .OFF_W  (PC_W)
  ) u_compactor (
    .i_valid  (w_push_en),
    .o_offset (w_push_off),
    .o_total  (w_push_cnt)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    logic [SUM_W-1:0] w_sum;
    assign w_sum     = SUM_W'(wp_q) + SUM_W'(w_push_off[i*PC_W +: PC_W]);
    assign w_slot[i] = PTR_W'(w_sum % SUM_W'(DEPTH));
  end

  // Storage array is intentionally not reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push_en[i]) begin
        mem_tag[w_slot[i]]  <= in_tag[i*TAG_W +: TAG_W];
        mem_data[w_slot[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_wp_sum = SUM_W'(wp_q) + SUM_W'(w_push_cnt);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      wp_d  = PTR_W'(w_wp_sum % SUM_W'(DEPTH));
      rp_d  = rp_q + PTR_W'(w_pop);
      cnt_d = cnt_q + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Head payload is forced to zero when empty so the unreset array never
  // leaks unknowns onto the bus.
  assign cdb_valid = (cnt_q != '0);
  assign cdb_tag   = cdb_valid ? mem_tag[rp_q]  : '0;
  assign cdb_data  = cdb_valid ? mem_data[rp_q] : '0;
  assign count     = cnt_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                cnt_q <= CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_cdb_completion_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_completion_queue
// Purpose  : Directed self-checking bench for cdb_completion_queue
//            (NUM_CH=4, DEPTH=16, DATA_W=32, TAG_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_completion_queue;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*TAG_W-1:0]  in_tag;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     flush;
  logic                     cdb_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [4:0]               count;

  int n_checks = 0;
  int n_errors = 0;

  cdb_completion_queue #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .cdb_ready (cdb_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel i gets tag ti and data dbase+i.
  task automatic drive(input logic [3:0] v, input logic [3:0] t0,
                       input logic [3:0] t1, input logic [3:0] t2,
                       input logic [3:0] t3, input logic [31:0] dbase);
    in_valid = v;
    in_tag   = {t3, t2, t1, t0};
    in_data  = {dbase + 32'd3, dbase + 32'd2, dbase + 32'd1, dbase};
  endtask

  logic [3:0]  exp_tag  [6];
  logic [31:0] exp_data [6];

  initial begin
    rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
    in_valid = '0; in_tag = '0; in_data = '0;

    // Reset state
    #2;
    check("rst_valid", cdb_valid, 0);
    check("rst_count", count, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single push then drain
    cdb_ready = 1'b1;
    drive(4'b0001, 4'd3, 4'd0, 4'd0, 4'd0, 32'hDEADBEEF);
    tick();
    in_valid = '0;
    check("single_valid", cdb_valid, 1);
    check("single_tag", cdb_tag, 3);
    check("single_data", cdb_data, 32'hDEADBEEF);
    check("single_count", count, 1);
    tick();
    check("single_empty_valid", cdb_valid, 0);
    check("single_empty_count", count, 0);

    // Four-way push, drained in channel order
    drive(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 32'd10);
    tick();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check("four_tag", cdb_tag, k + 1);
      check("four_data", cdb_data, 10 + k);
      check("four_count", count, 4 - k);
      tick();
    end
    check("four_empty_valid", cdb_valid, 0);
    check("four_empty_count", count, 0);

    // Fill with consumer stalled
    cdb_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(4'b1111, 4'(4*j), 4'(4*j+1), 4'(4*j+2), 4'(4*j+3), 32'(100 + 4*j));
      tick();
    end
    check("full_count", count, 16);
    check("full_ready", in_ready, 0);
    drive(4'b1111, 4'hF, 4'hF, 4'hF, 4'hF, 32'hBAD0);
    tick();
    check("full_ignored_count", count, 16);
    check("full_head_tag", cdb_tag, 0);
    in_valid = '0;
    cdb_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick();
      check("wrap_tag", cdb_tag, k);
      check("wrap_data", cdb_data, 100 + k);
      check("wrap_count", count, 16 - k);
      check("wrap_ready", in_ready, (16 - k) <= 12);
    end
    tick();
    check("wrap_empty_count", count, 0);

    // Push two while popping one at occupancy 5
    cdb_ready = 1'b0;
    drive(4'b1111, 4'd5, 4'd6, 4'd7, 4'd8, 32'd200);
    tick();
    drive(4'b0001, 4'd9, 4'd0, 4'd0, 4'd0, 32'd204);
    tick();
    check("pp_pre_count", count, 5);
    check("pp_pre_tag", cdb_tag, 5);
    drive(4'b0101, 4'hA, 4'd0, 4'hB, 4'd0, 32'd205);
    cdb_ready = 1'b1;
    tick();
    in_valid = '0;
    check("pp_count", count, 6);
    exp_tag[0] = 4'd6;  exp_data[0] = 32'd201;
    exp_tag[1] = 4'd7;  exp_data[1] = 32'd202;
    exp_tag[2] = 4'd8;  exp_data[2] = 32'd203;
    exp_tag[3] = 4'd9;  exp_data[3] = 32'd204;
    exp_tag[4] = 4'hA;  exp_data[4] = 32'd205;
    exp_tag[5] = 4'hB;  exp_data[5] = 32'd207;
    for (int k = 0; k < 6; k++) begin
      check("pp_tag", cdb_tag, exp_tag[k]);
      check("pp_data", cdb_data, exp_data[k]);
      tick();
    end
    check("pp_empty_count", count, 0);

    // Flush at occupancy 9 with all channels pushing
    cdb_ready = 1'b0;
    drive(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 32'd300);
    tick();
    drive(4'b1111, 4'd5, 4'd6, 4'd7, 4'd8, 32'd304);
    tick();
    drive(4'b0001, 4'd9, 4'd0, 4'd0, 4'd0, 32'd308);
    tick();
    check("flush_pre_count", count, 9);
    drive(4'b1111, 4'hC, 4'hC, 4'hC, 4'hC, 32'd400);
    cdb_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = '0;
    cdb_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", cdb_valid, 0);
    drive(4'b0001, 4'hE, 4'd0, 4'd0, 4'd0, 32'h12345678);
    tick();
    in_valid = '0;
    check("post_flush_valid", cdb_valid, 1);
    check("post_flush_tag", cdb_tag, 4'hE);
    check("post_flush_data", cdb_data, 32'h12345678);
    check("post_flush_count", count, 1);

    // Asynchronous reset between edges
    drive(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 32'd500);
    tick();
    in_valid = '0;
    check("pre_arst_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", cdb_valid, 0);
    check("arst_count", count, 0);
    check("arst_ready", in_ready, 1);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_arst_count", count, 0);
    check("post_arst_valid", cdb_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
